// File: rtl/fetch_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : fetch_ctrl_pkg                                             |
// | Brief   : Shared fetch-path types and constants (instruction address |
// |           and word types, reset/trap vectors, PC increment, fetch    |
// |           sequencer state encoding).                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_ctrl_pkg;

    localparam int INSN_ADDR_W = 32;
    localparam int INSN_DATA_W = 32;

    typedef logic [INSN_ADDR_W-1:0] InsnAddrPath;
    typedef logic [INSN_DATA_W-1:0] InsnPath;

    localparam InsnAddrPath INSN_RESET_VECTOR = 32'h0000_0000;
    localparam InsnAddrPath INSN_PC_INC       = 32'h0000_0004;
    localparam InsnAddrPath INSN_TRAP_VECTOR  = 32'h0000_0100;

    // Fetch sequencer states; DRAIN means one response is still owed by
    // memory and must be thrown away before the next request.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } FetchCtrlState;

endpackage

`default_nettype wire

// File: rtl/fetch_perf_counters.sv
// +----------------------------------------------------------------------+
// | Module  : fetch_perf_counters                                        |
// | Brief   : Free-running 32-bit event counters for the fetch sequencer |
// |           (decode handshakes, stall cycles, flushes). Only built     |
// |           when FETCH_CTRL_PERF_CNT_EN is defined.                    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetched_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] perfFetched_o,
    output logic [31:0] perfStall_o,
    output logic [31:0] perfFlush_o
);

    logic [31:0] fetched_q;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (fetched_i) fetched_q <= fetched_q + 32'd1;
            if (stall_i)   stall_q   <= stall_q + 32'd1;
            if (flush_i)   flush_q   <= flush_q + 32'd1;
        end
    end

    assign perfFetched_o = fetched_q;
    assign perfStall_o   = stall_q;
    assign perfFlush_o   = flush_q;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : fetch_ctrl                                                 |
// | Brief   : PC sequencer and instruction-memory handshake. Chooses     |
// |           hold / advance / load for the PC register each cycle and  |
// |           hands fetched words to decode with valid/ready.            |
// |           Optional macro FETCH_CTRL_PERF_CNT_EN adds perf counters.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = INSN_ADDR_W,
    parameter int                    INSN_WIDTH  = INSN_DATA_W,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = INSN_TRAP_VECTOR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pcAddr,
    output logic                  pcWrEnable,
    output logic [ADDR_WIDTH-1:0] pcAddrIn,
    output logic                  imemReq,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic                  imemGnt,
    input  logic                  imemValid,
    input  logic [INSN_WIDTH-1:0] imemData,
    output logic                  insnValid,
    output logic [INSN_WIDTH-1:0] insnOut,
    output logic [ADDR_WIDTH-1:0] insnAddr,
    input  logic                  decodeReady,
    input  logic                  redirectValid,
    input  logic [ADDR_WIDTH-1:0] redirectAddr,
    input  logic                  trap
`ifdef FETCH_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           perfFetched,
    output logic [31:0]           perfStall,
    output logic [31:0]           perfFlush
`endif
);

    FetchCtrlState         state_q, state_d;
    logic [INSN_WIDTH-1:0] insnOut_q, insnOut_d;
    logic [ADDR_WIDTH-1:0] insnAddr_q, insnAddr_d;

    logic                  flush_w;
    logic [ADDR_WIDTH-1:0] flushTarget_w;

    // Trap outranks a redirect arriving in the same cycle.
    assign flush_w       = trap | redirectValid;
    assign flushTarget_w = trap ? TRAP_VECTOR : redirectAddr;

    // Next-state and output decode; PC is held by default (pcWrEnable=1
    // writing back its own value) because the register increments otherwise.
    always_comb begin
        state_d    = state_q;
        insnOut_d  = insnOut_q;
        insnAddr_d = insnAddr_q;
        pcWrEnable = 1'b1;
        pcAddrIn   = pcAddr;
        imemReq    = 1'b0;
        imemAddr   = '0;
        insnValid  = 1'b0;

        if (flush_w) begin
            pcAddrIn = flushTarget_w;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imemReq  = 1'b1;
                imemAddr = pcAddr;
                // A grant taken in a flush cycle fetches the old PC, so its
                // response must be discarded.
                if (imemGnt) begin
                    state_d = flush_w ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (flush_w) begin
                    // If the response lands in the flush cycle itself it is
                    // consumed here, so there is nothing left to drain.
                    state_d = imemValid ? REQ : DRAIN;
                end else if (imemValid) begin
                    insnOut_d  = imemData;
                    insnAddr_d = pcAddr;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                insnValid = 1'b1;
                if (flush_w) begin
                    state_d = REQ;
                end else if (decodeReady) begin
                    pcWrEnable = 1'b0;
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                if (imemValid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            insnOut_q  <= '0;
            insnAddr_q <= '0;
        end else begin
            state_q    <= state_d;
            insnOut_q  <= insnOut_d;
            insnAddr_q <= insnAddr_d;
        end
    end

    assign insnOut  = insnOut_q;
    assign insnAddr = insnAddr_q;

`ifdef FETCH_CTRL_PERF_CNT_EN
    logic perfHandshake_w;
    logic perfStallCyc_w;

    assign perfHandshake_w = (state_q == HOLD) & decodeReady & ~flush_w;
    assign perfStallCyc_w  = (state_q == REQ) | (state_q == WAIT) | (state_q == DRAIN);

    fetch_perf_counters u_perf (
        .clk           (clk),
        .rst           (rst),
        .fetched_i     (perfHandshake_w),
        .stall_i       (perfStallCyc_w),
        .flush_i       (flush_w),
        .perfFetched_o (perfFetched),
        .perfStall_o   (perfStall),
        .perfFlush_o   (perfFlush)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// +----------------------------------------------------------------------+
// | Module  : tb_fetch_ctrl                                              |
// | Brief   : Self-checking bench for fetch_ctrl with a PC register,     |
// |           a latency-programmable instruction memory and a rule-based |
// |           expectation model. Honours FETCH_CTRL_PERF_CNT_EN.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcAddr;
    logic        pcWrEnable;
    logic [31:0] pcAddrIn;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt = 1'b0;
    logic        imemValid = 1'b0;
    logic [31:0] imemData = 32'h0;
    logic        insnValid;
    logic [31:0] insnOut;
    logic [31:0] insnAddr;
    logic        decodeReady;
    logic        redirectValid;
    logic [31:0] redirectAddr;
    logic        trap;
`ifdef FETCH_CTRL_PERF_CNT_EN
    logic [31:0] perfFetched, perfStall, perfFlush;
`endif

    fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .pcAddr        (pcAddr),
        .pcWrEnable    (pcWrEnable),
        .pcAddrIn      (pcAddrIn),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemGnt       (imemGnt),
        .imemValid     (imemValid),
        .imemData      (imemData),
        .insnValid     (insnValid),
        .insnOut       (insnOut),
        .insnAddr      (insnAddr),
        .decodeReady   (decodeReady),
        .redirectValid (redirectValid),
        .redirectAddr  (redirectAddr),
        .trap          (trap)
`ifdef FETCH_CTRL_PERF_CNT_EN
        ,
        .perfFetched   (perfFetched),
        .perfStall     (perfStall),
        .perfFlush     (perfFlush)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: every address holds a word derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // PC register: loads when written, otherwise increments.
    always @(posedge clk) begin
        if (rst)             pcAddr <= INSN_RESET_VECTOR;
        else if (pcWrEnable) pcAddr <= pcAddrIn;
        else                 pcAddr <= pcAddr + INSN_PC_INC;
    end

    // Environment knobs and memory state.
    int          resp_lat = 1;
    bit          gnt_en   = 1'b1;
    bit          pend     = 1'b0;
    int          pend_wait;
    logic [31:0] pend_addr;

    // Model state and observation logs.
    int          cyc = 0;
    int          last_rel = 0;
    bit          after_rst = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] m_fetched = 0, m_stall = 0, m_flush = 0;
    logic [31:0] hs_addr_q[$];
    int          hs_cyc_q[$];
    bit          req_log[0:4095];
    bit          val_log[0:4095];

    // Memory responder followed by the per-cycle model comparison.
    always @(negedge clk) begin
        logic        fl, hs, exp_we;
        logic [31:0] tgt;
        imemGnt   = imemReq && gnt_en;
        imemValid = 1'b0;
        if (pend && pend_wait == 0) begin
            imemValid = 1'b1;
            imemData  = mem_word(pend_addr);
            pend      = 1'b0;
        end else if (pend) begin
            pend_wait--;
        end
        if (imemGnt) begin
            pend      = 1'b1;
            pend_addr = imemAddr;
            pend_wait = resp_lat - 1;
        end
        #1;
        cyc++;
        if (rst) begin
            exp_addr  = INSN_RESET_VECTOR;
            after_rst = 1'b1;
            m_fetched = 0; m_stall = 0; m_flush = 0;
        end else begin
            fl  = trap | redirectValid;
            tgt = trap ? 32'h0000_0100 : redirectAddr;
            hs  = insnValid && decodeReady && !fl;
            if (after_rst) begin
                last_rel = cyc;
                chk("idle_req",      {31'b0, imemReq},   32'h0);
                chk("idle_valid",    {31'b0, insnValid}, 32'h0);
                chk("idle_insnOut",  insnOut,            32'h0);
                chk("idle_insnAddr", insnAddr,           32'h0);
            end
`ifdef FETCH_CTRL_PERF_CNT_EN
            chk("perfFetched", perfFetched, m_fetched);
            chk("perfStall",   perfStall,   m_stall);
            chk("perfFlush",   perfFlush,   m_flush);
`endif
            if (imemReq) chk("imemAddr", imemAddr, pcAddr);
            if (insnValid) begin
                chk("insnAddr", insnAddr, exp_addr);
                chk("insnOut",  insnOut,  mem_word(exp_addr));
            end
            exp_we = !hs || fl;
            chk("pcWrEnable", {31'b0, pcWrEnable}, {31'b0, exp_we});
            if (exp_we) chk("pcAddrIn", pcAddrIn, fl ? tgt : pcAddr);
            if (cyc < 4096) begin
                req_log[cyc] = imemReq;
                val_log[cyc] = insnValid;
            end
            if (hs) begin
                hs_addr_q.push_back(insnAddr);
                hs_cyc_q.push_back(cyc);
                exp_addr  = exp_addr + 32'd4;
                m_fetched = m_fetched + 1;
            end
            if (fl) begin
                exp_addr = tgt;
                m_flush  = m_flush + 1;
            end
            if (!insnValid && !after_rst) m_stall = m_stall + 1;
            after_rst = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k = 0;
        while (hs_addr_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("hs_timeout", hs_addr_q.size(), n);
    endtask

    task automatic wait_pend(input int budget);
        int k = 0;
        tick();
        while (!pend && k < budget) begin
            tick();
            k++;
        end
        chk("pend_timeout", {31'b0, pend}, 32'h1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!insnValid && k < budget) begin
            tick();
            k++;
        end
        chk("valid_timeout", {31'b0, insnValid}, 32'h1);
    endtask

    initial begin
        int vcnt;
        rst = 1'b1; decodeReady = 1'b1; redirectValid = 1'b0;
        redirectAddr = 32'h0; trap = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back fetches with single-cycle grant and response.
        wait_hs(3, 60);
        chk("hs0_addr", hs_addr_q[0], 32'h0);
        chk("hs1_addr", hs_addr_q[1], 32'h4);
        chk("hs2_addr", hs_addr_q[2], 32'h8);
        chk("first_latency", hs_cyc_q[0] - last_rel, 32'd3);
        chk("idle_then_req", {30'b0, req_log[last_rel], req_log[last_rel+1]}, 32'h1);

        // Decode stalls for 5 cycles while an instruction is held.
        decodeReady = 1'b0;
        wait_valid(20);
        chk("hold_addr", insnAddr, 32'hC);
        chk("hold_word", insnOut,  32'hFFF3_000C);
        vcnt = 0;
        repeat (5) begin
            tick();
            if (insnValid) vcnt++;
        end
        chk("hold_valid_cycles", vcnt, 32'd5);
        chk("hold_pc", pcAddr, 32'hC);
        chk("hold_word_end", insnOut, 32'hFFF3_000C);

        // Redirect while waiting on a slow response.
        resp_lat    = 3;
        decodeReady = 1'b1;
        wait_hs(4, 20);
        wait_pend(20);
        redirectValid = 1'b1; redirectAddr = 32'h200;
        tick();
        redirectValid = 1'b0;
        wait_hs(5, 60);
        chk("hs3_addr", hs_addr_q[3], 32'hC);
        chk("redirect_addr", hs_addr_q[4], 32'h200);
`ifdef FETCH_CTRL_PERF_CNT_EN
        chk("perf_fetched_lit", perfFetched, 32'd5);
        chk("perf_flush_lit",   perfFlush,   32'd1);
`endif

        // Trap and redirect together in HOLD with decode ready.
        resp_lat    = 1;
        decodeReady = 1'b0;
        wait_valid(20);
        trap = 1'b1; redirectValid = 1'b1; redirectAddr = 32'h300; decodeReady = 1'b1;
        tick();
        trap = 1'b0; redirectValid = 1'b0;
        chk("trap_pc", pcAddr, 32'h100);
        chk("trap_valid_cleared", {31'b0, insnValid}, 32'h0);
        wait_hs(6, 40);
        chk("trap_addr", hs_addr_q[5], 32'h100);

        // Reset in WAIT; the outstanding response lands two cycles later.
        resp_lat = 3;
        wait_pend(20);
        rst = 1'b1;
        tick();
        rst = 1'b0; gnt_en = 1'b0;
        repeat (4) tick();
        chk("stale_seen_idle_req", {30'b0, req_log[last_rel], req_log[last_rel+1]}, 32'h1);
        chk("stale_no_valid", {29'b0, val_log[last_rel], val_log[last_rel+1], val_log[last_rel+2]}, 32'h0);
        gnt_en = 1'b1; resp_lat = 1;
        wait_hs(7, 40);
        chk("reset_vector_addr", hs_addr_q[6], 32'h0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
